// File: rtl/div_pkg.sv
// Shared types and sizing for the HI/LO divide sequencer.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DZERO = 2'd1,
      ON    = 2'd2,
      END   = 2'd3
   } div_state_t;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Request/result bundle between EX-stage issue logic and the divide sequencer.
interface hilo_div_ctrl_if #(
   parameter int WIDTH = div_pkg::DIV_WIDTH
);
   import div_pkg::*;

   logic             start_i;
   logic             signed_i;
   logic [WIDTH-1:0] opdata1_i;
   logic [WIDTH-1:0] opdata2_i;
   logic             annul_i;
   logic             busy_o;
   logic             ready_o;
   logic             hilo_we_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      input  busy_o, ready_o, hilo_we_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      output busy_o, ready_o, hilo_we_o, hi_o, lo_o
   );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration on magnitudes: shift {rem,quo} left, subtract if it fits.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           fits;

   // rem < divisor on entry, so the shifted value never exceeds 2*divisor; the
   // borrow out of the WIDTH+1 bit subtract is therefore an exact compare.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - {1'b0, divisor};
      fits     = ~diff[WIDTH];
      rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/hilo_div_ctrl.sv
// DIV/DIVU sequencer: WIDTH restoring iterations on magnitudes, then sign fix and
// a single-cycle HI/LO write (HI = remainder, LO = quotient).
module hilo_div_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic           clk,
   input  logic           rst,
   hilo_div_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] rem_reg, rem_next;
   logic [WIDTH-1:0] quo_reg, quo_next;
   logic [WIDTH-1:0] dvs_reg, dvs_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic             s1_reg, s1_next;
   logic             s2_reg, s2_next;

   logic             s1_in, s2_in;
   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH-1:0] step_rem, step_quo;

   assign s1_in = bus.signed_i & bus.opdata1_i[WIDTH-1];
   assign s2_in = bus.signed_i & bus.opdata2_i[WIDTH-1];
   assign mag1  = s1_in ? -bus.opdata1_i : bus.opdata1_i;
   assign mag2  = s2_in ? -bus.opdata2_i : bus.opdata2_i;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .divisor  (dvs_reg),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rem_next   = rem_reg;
      quo_next   = quo_reg;
      dvs_next   = dvs_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      s1_next    = s1_reg;
      s2_next    = s2_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start_i && !bus.annul_i) begin
               s1_next  = s1_in;
               s2_next  = s2_in;
               dvs_next = mag2;
               rem_next = '0;
               cnt_next = '0;
               // Divide-by-zero keeps the raw dividend; it becomes HI unchanged.
               if (bus.opdata2_i == '0) begin
                  state_next = DZERO;
                  quo_next   = bus.opdata1_i;
               end else begin
                  state_next = ON;
                  quo_next   = mag1;
               end
            end
         end
         DZERO: begin
            if (bus.annul_i) begin
               state_next = IDLE;
            end else begin
               state_next = END;
               hi_next    = quo_reg;
               lo_next    = '1;
            end
         end
         ON: begin
            if (bus.annul_i) begin
               state_next = IDLE;
            end else begin
               rem_next = step_rem;
               quo_next = step_quo;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_CNT) begin
                  // Remainder follows the dividend sign; MIN/-1 wraps back to MIN.
                  state_next = END;
                  hi_next    = s1_reg ? -step_rem : step_rem;
                  lo_next    = (s1_reg ^ s2_reg) ? -step_quo : step_quo;
               end
            end
         end
         END: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvs_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         s1_reg    <= 1'b0;
         s2_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rem_reg   <= rem_next;
         quo_reg   <= quo_next;
         dvs_reg   <= dvs_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
         s1_reg    <= s1_next;
         s2_reg    <= s2_next;
      end
   end

   assign bus.busy_o    = (state_reg != IDLE);
   assign bus.ready_o   = (state_reg == END);
   assign bus.hilo_we_o = (state_reg == END);
   assign bus.hi_o      = hi_reg;
   assign bus.lo_o      = lo_reg;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Randomised and directed checks of hilo_div_ctrl against a plain-arithmetic divide model.
module tb_hilo_div_ctrl;

   logic clk;
   logic rst;

   hilo_div_ctrl_if #(.WIDTH(32)) bus ();

   hilo_div_ctrl #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 output logic [31:0] hi, output logic [31:0] lo);
      int sa;
      int sb;
      if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else if (!sgn) begin
         lo = a / b;
         hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         lo = 32'h8000_0000;
         hi = 32'd0;
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         lo = sa / sb;
         hi = sa % sb;
      end
   endfunction

   // Issue one divide and watch 40 cycles: busy profile, latency, single-cycle strobe, result.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
      logic [31:0] exp_hi, exp_lo;
      int exp_lat;
      int seen;
      int ready_cnt;
      model(a, b, sgn, exp_hi, exp_lo);
      exp_lat   = (b == 32'd0) ? 2 : 33;
      seen      = -1;
      ready_cnt = 0;
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.signed_i  = sgn;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      @(negedge clk);
      bus.start_i = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         total++;
         if (bus.busy_o !== (c <= exp_lat)) begin
            bad++;
            $display("FAIL %s busy c%0d: got %b want %b", tag, c, bus.busy_o, (c <= exp_lat));
         end
         total++;
         if (bus.hilo_we_o !== bus.ready_o) begin
            bad++;
            $display("FAIL %s we_vs_ready c%0d: got we=%b ready=%b", tag, c, bus.hilo_we_o, bus.ready_o);
         end
         if (bus.ready_o === 1'b1) begin
            ready_cnt++;
            if (seen < 0) seen = c;
            total++;
            if (bus.hi_o !== exp_hi) begin
               bad++;
               $display("FAIL %s hi: got %h want %h", tag, bus.hi_o, exp_hi);
            end
            total++;
            if (bus.lo_o !== exp_lo) begin
               bad++;
               $display("FAIL %s lo: got %h want %h", tag, bus.lo_o, exp_lo);
            end
         end
      end
      total++;
      if (seen != exp_lat) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", tag, seen, exp_lat);
      end
      total++;
      if (ready_cnt != 1) begin
         bad++;
         $display("FAIL %s ready_cycles: got %0d want 1", tag, ready_cnt);
      end
      last_hi = exp_hi;
      last_lo = exp_lo;
      $display("div %s: %h / %h sgn=%b -> hi=%h lo=%h", tag, a, b, sgn, exp_hi, exp_lo);
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({bus.busy_o, bus.ready_o, bus.hilo_we_o} !== 3'b000) begin
         bad++;
         $display("FAIL reset flags: got %b want 000", {bus.busy_o, bus.ready_o, bus.hilo_we_o});
      end
      total++;
      if (bus.hi_o !== 32'd0) begin
         bad++;
         $display("FAIL reset hi: got %h want 0", bus.hi_o);
      end
      total++;
      if (bus.lo_o !== 32'd0) begin
         bad++;
         $display("FAIL reset lo: got %h want 0", bus.lo_o);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (bus.busy_o !== 1'b0) begin
         bad++;
         $display("FAIL post_reset busy: got %b want 0", bus.busy_o);
      end
      $display("reset: outputs checked");
   endtask

   task automatic test_directed();
      run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
      run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
      run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1");
      run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "divu_big_2");
   endtask

   task automatic test_div_zero();
      run_div(32'd5, 32'd0, 1'b1, "div_5_0");
      run_div(32'hFFFF_FF00, 32'd0, 1'b1, "div_neg_0");
      run_div(32'h8765_4321, 32'd0, 1'b0, "divu_x_0");
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic sgn;
      for (int i = 0; i < 40; i++) begin
         a   = $urandom;
         b   = $urandom;
         sgn = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = $urandom_range(0, 15);
            1: b = 32'd0;
            2: a = 32'h8000_0000;
            3: b = 32'hFFFF_FFFF;
            4: a = $urandom_range(0, 1000);
            default: ;
         endcase
         run_div(a, b, sgn, "random");
      end
   endtask

   task automatic test_annul();
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'h1234_5678;
      bus.opdata2_i = 32'd7;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (9) @(negedge clk);
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i = 1'b0;
      total++;
      if (bus.busy_o !== 1'b0) begin
         bad++;
         $display("FAIL annul busy: got %b want 0", bus.busy_o);
      end
      total++;
      if (bus.hi_o !== last_hi || bus.lo_o !== last_lo) begin
         bad++;
         $display("FAIL annul hold: got %h/%h want %h/%h", bus.hi_o, bus.lo_o, last_hi, last_lo);
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         total++;
         if (bus.hilo_we_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            bad++;
            $display("FAIL annul no_write c%0d: got we=%b ready=%b want 0", c, bus.hilo_we_o, bus.ready_o);
         end
      end
      $display("annul: divide aborted at iteration 10");
      run_div(32'd9, 32'd3, 1'b0, "after_annul_9_3");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b1;
      bus.opdata1_i = 32'hDEAD_BEEF;
      bus.opdata2_i = 32'd13;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++;
      if ({bus.busy_o, bus.ready_o, bus.hilo_we_o} !== 3'b000) begin
         bad++;
         $display("FAIL async_rst flags: got %b want 000", {bus.busy_o, bus.ready_o, bus.hilo_we_o});
      end
      total++;
      if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin
         bad++;
         $display("FAIL async_rst hilo: got %h/%h want 0/0", bus.hi_o, bus.lo_o);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL async_rst idle c%0d: got ready=%b busy=%b want 0", c, bus.ready_o, bus.busy_o);
         end
      end
      // Short divide-by-zero, then hold a new start only across the END cycle.
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'd11;
      bus.opdata2_i = 32'd0;
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      total++;
      if (bus.ready_o !== 1'b1 || bus.hi_o !== 32'd11 || bus.lo_o !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL end_start first: got ready=%b hi=%h lo=%h want 1/0000000b/ffffffff",
                  bus.ready_o, bus.hi_o, bus.lo_o);
      end
      bus.start_i   = 1'b1;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      @(negedge clk);
      bus.start_i = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         total++;
         if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.hilo_we_o !== 1'b0) begin
            bad++;
            $display("FAIL end_start ignored c%0d: got busy=%b ready=%b we=%b want 0",
                     c, bus.busy_o, bus.ready_o, bus.hilo_we_o);
         end
      end
      last_hi = 32'd11;
      last_lo = 32'hFFFF_FFFF;
      $display("async_reset: reset mid-divide, start during END dropped");
   endtask

   initial begin
      rst           = 1'b0;
      bus.start_i   = 1'b0;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;
      bus.annul_i   = 1'b0;
      test_reset();
      test_directed();
      test_div_zero();
      test_random();
      test_annul();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
